// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div as fixed-latency
// multi-cycle operations and raises busy for the hazard unit while one is in flight.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    function automatic logic [63:0] mul_signed(input logic signed [31:0] x,
                                               input logic signed [31:0] y);
        logic signed [63:0] xs;
        logic signed [63:0] ys;
        xs = x;
        ys = y;
        return xs * ys;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Returns {remainder, quotient}; the one overflowing signed case is pinned explicitly.
    function automatic logic [63:0] div_signed(input logic signed [31:0] x,
                                               input logic signed [31:0] y);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (y == 32'sd0) begin
            q = '0;
            r = '0;
        end else if (x == 32'sh8000_0000 && y == -32'sd1) begin
            q = x;
            r = '0;
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 64'd0;
        return {x % y, x / y};
    endfunction

    logic [31:0]      res_hi_p0;
    logic [31:0]      res_lo_p0;
    logic             res_wr_p0;
    logic             res_md_p0;
    logic [CNT_W-1:0] res_cnt_p0;

    logic [31:0]      pend_hi_p1;
    logic [31:0]      pend_lo_p1;
    logic             pend_wr_p1;
    logic [CNT_W-1:0] cnt;

    // Stage p0: full result computed combinationally from the forwarded operands
    always_comb begin
        res_hi_p0  = '0;
        res_lo_p0  = '0;
        res_wr_p0  = 1'b0;
        res_md_p0  = 1'b0;
        res_cnt_p0 = '0;
        case (op)
            OP_MULT: begin
                {res_hi_p0, res_lo_p0} = mul_signed(a, b);
                res_wr_p0  = 1'b1;
                res_md_p0  = 1'b1;
                res_cnt_p0 = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                {res_hi_p0, res_lo_p0} = mul_unsigned(a, b);
                res_wr_p0  = 1'b1;
                res_md_p0  = 1'b1;
                res_cnt_p0 = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
                {res_hi_p0, res_lo_p0} = div_signed(a, b);
                res_wr_p0  = (b != 32'd0);
                res_md_p0  = 1'b1;
                res_cnt_p0 = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                {res_hi_p0, res_lo_p0} = div_unsigned(a, b);
                res_wr_p0  = (b != 32'd0);
                res_md_p0  = 1'b1;
                res_cnt_p0 = CNT_W'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Stage p1: pending result held while the counter runs down, then committed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            pend_hi_p1 <= '0;
            pend_lo_p1 <= '0;
            pend_wr_p1 <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (pend_wr_p1) begin
                    hi <= pend_hi_p1;
                    lo <= pend_lo_p1;
                end
            end
        end else if (start) begin
            if (op == OP_MTHI) begin
                hi <= a;
            end else if (op == OP_MTLO) begin
                lo <= a;
            end else if (res_md_p0) begin
                pend_hi_p1 <= res_hi_p0;
                pend_lo_p1 <= res_lo_p0;
                pend_wr_p1 <= res_wr_p0;
                cnt        <= res_cnt_p0;
                busy       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed plan cases plus random ops checked against an
// arithmetic model of HI/LO and the busy window length.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Architectural effect of one accepted command on HI/LO.
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned up;
        case (mop)
            3'd0: begin
                sp = longint'(int'(ma)) * longint'(int'(mb));
                exp_hi = sp[63:32];
                exp_lo = sp[31:0];
            end
            3'd1: begin
                up = longint'(ma) * longint'(mb);
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd2: if (mb != 0) begin
                sq = longint'(int'(ma)) / longint'(int'(mb));
                sr = longint'(int'(ma)) % longint'(int'(mb));
                exp_lo = sq[31:0];
                exp_hi = sr[31:0];
            end
            3'd3: if (mb != 0) begin
                exp_lo = ma / mb;
                exp_hi = ma % mb;
            end
            3'd4: exp_hi = ma;
            3'd5: exp_lo = ma;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int n;
        old_hi = exp_hi;
        old_lo = exp_lo;
        n = (rop <= 3'd1) ? MC : (rop <= 3'd3) ? DC : 0;
        issue(rop, ra, rb);
        model(rop, ra, rb);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_window", {31'd0, busy}, 32'd1);
            chk("hi_hold", hi, old_hi);
            chk("lo_hold", lo, old_lo);
        end
        @(negedge clk);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("hi_result", hi, exp_hi);
        chk("lo_result", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFF1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_lo_const", lo, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_hi_const", hi, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_lo_const", lo, 32'h8000_0000);
        chk("divovf_hi_const", hi, 32'h0000_0000);
        run_op(3'd5, 32'd0, 32'd0);
        run_op(3'd4, 32'h1234_5678, 32'd0);
        run_op(3'd3, 32'd7, 32'd0);
        chk("divz_hi_const", hi, 32'h1234_5678);
        chk("divz_lo_const", lo, 32'd0);

        // Overlap: commands during the busy window and on the commit edge are dropped
        issue(3'd0, 32'd2, 32'd3);
        model(3'd0, 32'd2, 32'd3);
        for (int i = 1; i <= MC; i++) begin
            @(negedge clk);
            chk("ovl_busy", {31'd0, busy}, 32'd1);
            start = 1'b0;
            if (i == 2) begin
                start = 1'b1; op = 3'd5; a = 32'h0000_AAAA; b = '0;
            end else if (i == MC) begin
                start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd2;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("ovl_busy_end", {31'd0, busy}, 32'd0);
        chk("ovl_lo", lo, 32'd6);
        chk("ovl_hi", hi, 32'd0);
        @(negedge clk);
        chk("ovl_no_restart", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a div
        issue(3'd2, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_lo", lo, 32'd0);
        end
        run_op(3'd1, 32'd3, 32'd4);
        chk("post_rst_multu", lo, 32'd12);

        run_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        run_op(3'd7, 32'hCAFE_F00D, 32'd2);

        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit beside the ALU in the EX stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div and divu as multi-cycle operations, plus mthi and mtlo as single-cycle writes.
- Owns the architectural HI/LO registers and drives the busy flag that the hazard unit uses to stall mfhi/mflo/md instructions in D.
- Operands come from the EX-stage forwarded values of rs and rt.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu; must be >= 1.
- DIV_CYCLES, 10, number of busy cycles for div/divu; must be >= 1.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request from EX: the instruction in EX is a mult/div/mthi/mtlo and is not being flushed.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6 and 7 are reserved.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- busy  output  1  a multi-cycle operation is in flight.
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.

Behaviour:
- Reset (async, any time): busy=0, hi=0, lo=0, cycle counter=0, pending results cleared. An operation in flight is discarded with no HI/LO update.
- Command acceptance: a command is accepted on a rising edge where start=1 and busy=0.
  - start=1 while busy=1 is ignored entirely. The hazard unit is responsible for never issuing such a command.
  - Reserved op values are ignored and do not set busy.
- mthi/mtlo:
  - hi (or lo) <= a on the accepting edge; visible the next cycle.
  - busy stays 0; the other register is unchanged.
- mult/multu/div/divu:
  - On the accepting edge, the full result is computed combinationally from a and b and latched into pending_hi/pending_lo.
  - The counter loads N (MULT_CYCLES or DIV_CYCLES) and busy goes to 1 the following cycle.
  - The counter decrements each edge while busy=1.
  - On the edge where the counter goes 1->0: hi<=pending_hi, lo<=pending_lo, busy<=0.
  - Net effect: accept at edge t, busy=1 during cycles t+1 .. t+N, new HI/LO visible with busy=0 from cycle t+N+1.
  - hi/lo keep their old values throughout the busy window.
- States (implicit in the counter):
  - IDLE (counter=0, busy=0).
  - RUN (counter>0, busy=1).
  - IDLE -> RUN on accept of a multi-cycle op.
  - RUN -> IDLE on the commit edge.
  - A start arriving on the commit edge is ignored, because busy is still 1 on that edge.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = bits 63:32, lo = bits 31:0.
  - multu: the same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend a.
  - divu: unsigned quotient and remainder.
  - div with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu with b=0): busy runs the full DIV_CYCLES, and hi/lo are left unchanged at commit.
- Outputs hi, lo and busy are driven directly from registers; there is no combinational path from the inputs to the outputs.

Test Plan:
- Reset, then mult with a=0xFFFFFFFD (-3), b=5 -> busy=1 for exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1 appear on the cycle busy falls; hi/lo stay 0 during busy.
- multu with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- div with a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. div with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x12345678, then divu a=7, b=0 -> hi=0x12345678 the next cycle; the divu runs 10 busy cycles and leaves hi=0x12345678, lo=0 unchanged.
- Overlap checks:
  - Start mult with a=2, b=3.
  - Assert start with mtlo a=0xAAAA at busy cycle 2 -> ignored.
  - Assert start with divu on the commit edge -> ignored.
  - Final state: lo=6, hi=0, busy=0.
- Start div with a=100, b=7, then assert reset asynchronously between clock edges at busy cycle 4 -> busy, hi and lo drop to 0 immediately without waiting for a clock edge; nothing commits afterwards. A new multu with a=3, b=4 then gives lo=12.
